// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array host controller.
package sa_pkg;
  localparam int DIN_WIDTH_DEF = 8;
  localparam int N_DEF         = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;
endpackage

// File: rtl/sa_skid_buf.sv
// Two-entry register FIFO catching operand beats; head visible combinationally, zero latency.
// No internal backpressure: the caller only pushes when room is guaranteed.
module sa_skid_buf #(
  parameter int W = 64
)(
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_pop_dat,
  output logic [1:0]   o_cnt
);
  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_push_dat;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop)
        r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_pop_dat = r_mem[r_rptr];
  assign o_cnt     = r_cnt;
endmodule

// File: rtl/systolic_host_ctrl.sv
// Streams M+1 operand beats into the array input FIFO, then drains N result rows into the result buffer.
// Operand reads are throttled by skid-buffer room; writes stall combinationally on arr_in_fifo_full.
module systolic_host_ctrl
  import sa_pkg::*;
#(
  parameter int DIN_WIDTH = DIN_WIDTH_DEF,
  parameter int N         = N_DEF,
  parameter int BUS_WIDTH = 2*DIN_WIDTH*N
)(
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           M_minus_one,
  output logic                 busy,
  output logic                 done,
  output logic                 op_rd_en,
  output logic [7:0]           op_rd_addr,
  input  logic [BUS_WIDTH-1:0] op_rd_data,
  output logic [BUS_WIDTH-1:0] arr_din,
  output logic                 arr_wr_fifo,
  input  logic                 arr_in_fifo_full,
  output logic                 arr_rd_fifo,
  input  logic [BUS_WIDTH-1:0] arr_dout,
  input  logic                 arr_out_fifo_empty,
  output logic                 res_wr_en,
  output logic [$clog2(N)-1:0] res_wr_addr,
  output logic [BUS_WIDTH-1:0] res_wr_data
);
  localparam int AW = $clog2(N);
  localparam int PW = $clog2(N+1);

  state_t               r_state;
  state_t               w_next;
  logic [7:0]           r_m;
  logic [8:0]           r_rd_cnt;
  logic [8:0]           r_wr_cnt;
  logic                 r_inflight;
  logic [PW-1:0]        r_pop_cnt;
  logic                 r_pop_vld;
  logic [AW-1:0]        r_res_cnt;
  logic                 w_start_ok;
  logic                 w_wr;
  logic                 w_issue;
  logic                 w_pop;
  logic [1:0]           w_sb_cnt;
  logic [2:0]           w_occ;
  logic [BUS_WIDTH-1:0] w_sb_dat;

  // Occupancy the skid buffer will have once the in-flight beat lands and this cycle's write leaves.
  assign w_start_ok = (r_state == IDLE) && start;
  assign w_wr       = (r_state == FEED) && (w_sb_cnt != 2'd0) && !arr_in_fifo_full;
  assign w_occ      = {1'b0, w_sb_cnt} + {2'b0, r_inflight} - {2'b0, w_wr};
  assign w_issue    = (r_state == FEED) && (r_rd_cnt <= {1'b0, r_m}) && (w_occ < 3'd2);
  assign w_pop      = (r_state == DRAIN) && !arr_out_fifo_empty && (r_pop_cnt < PW'(N));

  sa_skid_buf #(.W(BUS_WIDTH)) u_skid (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .i_push     (r_inflight),
    .i_push_dat (op_rd_data),
    .i_pop      (w_wr),
    .o_pop_dat  (w_sb_dat),
    .o_cnt      (w_sb_cnt)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = FEED;
      FEED:    if (w_wr && (r_wr_cnt == {1'b0, r_m})) w_next = DRAIN;
      DRAIN:   if (r_pop_vld && (r_res_cnt == AW'(N-1))) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != IDLE);
    done        = (r_state == FIN);
    op_rd_en    = w_issue;
    op_rd_addr  = r_rd_cnt[7:0];
    arr_wr_fifo = w_wr;
    arr_din     = w_wr ? w_sb_dat : '0;
    arr_rd_fifo = w_pop;
    res_wr_en   = r_pop_vld;
    res_wr_addr = r_res_cnt;
    res_wr_data = r_pop_vld ? arr_dout : '0;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m        <= 8'd0;
      r_rd_cnt   <= 9'd0;
      r_wr_cnt   <= 9'd0;
      r_inflight <= 1'b0;
      r_pop_cnt  <= '0;
      r_pop_vld  <= 1'b0;
      r_res_cnt  <= '0;
    end else begin
      r_inflight <= w_issue;
      r_pop_vld  <= w_pop;
      if (w_start_ok) begin
        r_m       <= M_minus_one;
        r_rd_cnt  <= 9'd0;
        r_wr_cnt  <= 9'd0;
        r_pop_cnt <= '0;
        r_res_cnt <= '0;
      end else begin
        if (w_issue)   r_rd_cnt  <= r_rd_cnt + 9'd1;
        if (w_wr)      r_wr_cnt  <= r_wr_cnt + 9'd1;
        if (w_pop)     r_pop_cnt <= r_pop_cnt + PW'(1);
        if (r_pop_vld) r_res_cnt <= r_res_cnt + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_systolic_host_ctrl.sv
// Randomized bench: memory/FIFO responders plus a queue-level model of the expected beat and result streams.
module tb_systolic_host_ctrl;
  localparam int DW = 8;
  localparam int NN = 4;
  localparam int BW = 2*DW*NN;
  localparam int AW = $clog2(NN);

  logic          sys_clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    M_minus_one;
  logic          busy, done, op_rd_en;
  logic [7:0]    op_rd_addr;
  logic [BW-1:0] op_rd_data;
  logic [BW-1:0] arr_din;
  logic          arr_wr_fifo;
  logic          arr_in_fifo_full;
  logic          arr_rd_fifo;
  logic [BW-1:0] arr_dout;
  logic          arr_out_fifo_empty;
  logic          res_wr_en;
  logic [AW-1:0] res_wr_addr;
  logic [BW-1:0] res_wr_data;

  always #5 sys_clk = ~sys_clk;

  systolic_host_ctrl #(.DIN_WIDTH(DW), .N(NN), .BUS_WIDTH(BW)) dut (
    .sys_clk            (sys_clk),
    .rst_n              (rst_n),
    .start              (start),
    .M_minus_one        (M_minus_one),
    .busy               (busy),
    .done               (done),
    .op_rd_en           (op_rd_en),
    .op_rd_addr         (op_rd_addr),
    .op_rd_data         (op_rd_data),
    .arr_din            (arr_din),
    .arr_wr_fifo        (arr_wr_fifo),
    .arr_in_fifo_full   (arr_in_fifo_full),
    .arr_rd_fifo        (arr_rd_fifo),
    .arr_dout           (arr_dout),
    .arr_out_fifo_empty (arr_out_fifo_empty),
    .res_wr_en          (res_wr_en),
    .res_wr_addr        (res_wr_addr),
    .res_wr_data        (res_wr_data)
  );

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] mem [256];
  logic [BW-1:0] outq [NN];
  bit            pend_rd;
  logic [7:0]    pend_addr;
  bit            pend_pop;
  int            pop_idx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks that nothing is strobed or busy while the block should be sitting in IDLE.
  task automatic idle_check(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge sys_clk);
      start              = 1'b0;
      arr_in_fifo_full   = 1'($urandom_range(0, 1));
      arr_out_fifo_empty = 1'b0;
      op_rd_data         = {$urandom, $urandom};
      arr_dout           = {$urandom, $urandom};
      #1;
      chk("idle_strobes", {busy, done, op_rd_en, arr_wr_fifo, arr_rd_fifo, res_wr_en}, 0);
    end
  endtask

  task automatic run_job(input int m, input int fmode, input int emode, input bit data_is_addr,
                         input bit start_in_feed, input bit start_at_done, input bit rst_mid);
    int wr_n = 0, rd_n = 0, res_n = 0, pops = 0, done_n = 0;
    int last_res = -100, last_wr = -100;
    bit did_rst = 0;
    for (int a = 0; a < 256; a++)
      mem[a] = data_is_addr ? BW'(a) : {$urandom, $urandom};
    for (int k = 0; k < NN; k++)
      outq[k] = {$urandom, $urandom};
    pend_rd = 0; pend_pop = 0; pop_idx = 0;

    @(negedge sys_clk);
    start = 1'b1; M_minus_one = 8'(m);
    arr_in_fifo_full = 1'b0; arr_out_fifo_empty = 1'b1;
    #1;
    chk("busy_before_start", busy, 0);

    for (int cyc = 1; cyc < 4000; cyc++) begin
      @(negedge sys_clk);
      start = 1'b0;
      M_minus_one = 8'($urandom);
      if (start_in_feed && cyc == 3) begin
        start = 1'b1; M_minus_one = 8'(m ^ 5);
      end
      if (start_at_done && res_n == NN && cyc == last_res + 1)
        start = 1'b1;
      case (fmode)
        0:       arr_in_fifo_full = 1'b0;
        1:       arr_in_fifo_full = (cyc >= 2 && cyc <= 6);
        default: arr_in_fifo_full = ($urandom_range(0, 2) == 0);
      endcase
      case (emode)
        0:       arr_out_fifo_empty = (cyc % 2 == 1);
        1:       arr_out_fifo_empty = ($urandom_range(0, 2) == 0);
        default: arr_out_fifo_empty = 1'b0;
      endcase
      op_rd_data = pend_rd ? mem[pend_addr] : {$urandom, $urandom};
      arr_dout   = (pend_pop && pop_idx >= 1 && pop_idx <= NN) ? outq[pop_idx-1] : {$urandom, $urandom};
      #1;
      if (cyc == 1) chk("busy_feed", busy, 1);
      if (op_rd_en) begin
        chk("rd_addr", op_rd_addr, rd_n);
        rd_n++;
      end
      if (arr_wr_fifo) begin
        chk("wr_while_full", arr_in_fifo_full, 0);
        chk("wr_data", arr_din, mem[wr_n % 256]);
        if (fmode == 0 && wr_n > 0) chk("wr_back_to_back", cyc, last_wr + 1);
        wr_n++; last_wr = cyc;
      end
      if (arr_rd_fifo) begin
        chk("pop_while_empty", arr_out_fifo_empty, 0);
        chk("pop_after_feed", wr_n, m + 1);
        pops++;
      end
      if (res_wr_en) begin
        chk("res_addr", res_wr_addr, res_n % NN);
        chk("res_data", res_wr_data, outq[res_n % NN]);
        res_n++; last_res = cyc;
      end
      if (done) begin
        done_n++;
        chk("done_timing", cyc, last_res + 1);
        chk("busy_at_done", busy, 1);
      end
      if (done_n > 0 && cyc >= last_res + 2)
        chk("idle_after_done", {busy, done, op_rd_en, arr_wr_fifo, arr_rd_fifo, res_wr_en}, 0);
      pend_rd   = op_rd_en;
      pend_addr = op_rd_addr;
      if (arr_rd_fifo) pop_idx++;
      pend_pop  = arr_rd_fifo;
      if (rst_mid && res_n == 2) begin
        rst_n = 1'b0;
        #1;
        chk("rst_strobes", {busy, done, op_rd_en, arr_wr_fifo, arr_rd_fifo, res_wr_en}, 0);
        chk("rst_arr_din", arr_din, 0);
        chk("rst_res_data", res_wr_data, 0);
        chk("rst_addrs", {op_rd_addr, res_wr_addr}, 0);
        @(posedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b1;
        pend_rd = 0; pend_pop = 0;
        did_rst = 1;
        break;
      end
      if (done_n > 0 && cyc >= last_res + 4) break;
      @(posedge sys_clk);
    end

    if (rst_mid) begin
      chk("rst_was_applied", did_rst, 1);
      idle_check(4);
    end else begin
      chk("beats_read", rd_n, m + 1);
      chk("beats_written", wr_n, m + 1);
      chk("pops_total", pops, NN);
      chk("results_total", res_n, NN);
      chk("done_pulses", done_n, 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; M_minus_one = 8'd0;
    arr_in_fifo_full = 1'b0; arr_out_fifo_empty = 1'b1;
    op_rd_data = '0; arr_dout = '0;
    @(negedge sys_clk);
    #1;
    chk("reset_strobes", {busy, done, op_rd_en, arr_wr_fifo, arr_rd_fifo, res_wr_en}, 0);
    chk("reset_data", arr_din | res_wr_data, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    idle_check(3);

    run_job(3,   0, 0, 1, 0, 0, 0);
    run_job(7,   1, 1, 0, 0, 0, 0);
    run_job(0,   0, 2, 0, 0, 0, 0);
    run_job(5,   2, 1, 0, 1, 1, 0);
    run_job(4,   0, 2, 0, 0, 0, 1);
    run_job(4,   0, 2, 1, 0, 0, 0);
    run_job(255, 2, 1, 0, 0, 0, 0);
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(0, 40), $urandom_range(0, 2), $urandom_range(0, 2), 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
